// File: rtl/raster_pkg.sv
// Constants and angle arithmetic shared by the sequencer and the geometry ROM generators.
package raster_pkg;

  localparam int ANGLE_W   = 9;
  localparam int ANGLE_MAX = 360;

  typedef logic [ANGLE_W-1:0] angle_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // One advance step; with bounce set the angle clamps to 0 or ANGLE_MAX-1 instead of wrapping.
  function automatic angle_t angle_step(input angle_t a, input logic down,
                                        input logic [9:0] step, input logic bounce);
    logic [9:0] s;
    s = {1'b0, a};
    if (!down) begin
      s = s + step;
      if (s >= 10'(ANGLE_MAX)) begin
        s = bounce ? 10'(ANGLE_MAX - 1) : s - 10'(ANGLE_MAX);
      end
    end else if (s < step) begin
      s = bounce ? 10'd0 : s + 10'(ANGLE_MAX) - step;
    end else begin
      s = s - step;
    end
    return s[ANGLE_W-1:0];
  endfunction

  // True when the next step in the given direction would leave 0..ANGLE_MAX-1.
  function automatic logic angle_at_limit(input angle_t a, input logic down,
                                          input logic [9:0] step);
    logic [9:0] s;
    s = {1'b0, a};
    if (down) begin
      return s < step;
    end
    return (s + step) >= 10'(ANGLE_MAX);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter, one-cycle press pulse on a
// debounced rising level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk_pix,
  input  logic resetn,
  input  logic btn,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync0_q, sync0_d;
  logic             sync1_q, sync1_d;
  logic             prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;

  always_comb begin
    sync0_d = btn;
    sync1_d = sync0_q;
    prev_d  = sync1_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    // The counter saturates once stable, so the level simply keeps tracking the settled input.
    if (sync1_q != prev_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync1_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    press_d = level_d & ~level_q;
  end

  always_ff @(posedge clk_pix or negedge resetn) begin
    if (!resetn) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync0_q <= sync0_d;
      sync1_q <= sync1_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/angle_sequencer.sv
// Frame-synchronous rotation angle sequencer with pause/direction buttons.
// Define ANGLE_BOUNCE_EN to make the angle ping-pong between 0 and 359 instead of wrapping.
module angle_sequencer
  import raster_pkg::*;
#(
  parameter int STEP            = 1,
  parameter int FRAME_DIV       = 1,
  parameter int VSYNC_ACT_LOW   = 1,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic               clk_pix,
  input  logic               resetn,
  input  logic               vsync,
  input  logic               btn_pause,
  input  logic               btn_dir,
  output logic [ANGLE_W-1:0] angle,
  output logic               frame_tick,
  output logic               paused,
  output logic               dir
);

  localparam logic [9:0] STEP_V    = 10'(STEP);
  localparam logic [7:0] FCNT_LAST = 8'(FRAME_DIV - 1);
`ifdef ANGLE_BOUNCE_EN
  localparam logic BOUNCE = 1'b1;
`else
  localparam logic BOUNCE = 1'b0;
`endif

  logic [1:0] btn_raw;
  logic [1:0] press;

  assign btn_raw = {btn_dir, btn_pause};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk_pix(clk_pix),
        .resetn (resetn),
        .btn    (btn_raw[gi]),
        .press  (press[gi])
      );
    end
  endgenerate

  logic   vact_q, vact_d;
  logic   frame_tick_q, frame_tick_d;
  logic [7:0] fcnt_q, fcnt_d;
  angle_t angle_q, angle_d;
  logic   paused_q, paused_d;
  logic   dir_q, dir_d;

  logic   vact;
  logic   tick;
  logic   advance;
  logic   going_down;

  always_comb begin
    vact         = (VSYNC_ACT_LOW != 0) ? ~vsync : vsync;
    tick         = vact & ~vact_q;
    advance      = tick & ~paused_q & (fcnt_q == FCNT_LAST);
    going_down   = (dir_q == DIR_DOWN);

    vact_d       = vact;
    frame_tick_d = tick;
    fcnt_d       = fcnt_q;
    angle_d      = angle_q;
    paused_d     = paused_q ^ press[0];
    dir_d        = dir_q ^ press[1];

    if (tick && !paused_q) begin
      fcnt_d = (fcnt_q == FCNT_LAST) ? 8'd0 : fcnt_q + 8'd1;
    end
    // The advance sees dir_q/paused_q, i.e. the values before any same-cycle button toggle.
    if (advance) begin
      angle_d = angle_step(angle_q, going_down, STEP_V, BOUNCE);
    end
`ifdef ANGLE_BOUNCE_EN
    if (advance && angle_at_limit(angle_q, going_down, STEP_V)) begin
      dir_d = ~dir_q;
    end
`endif
  end

  always_ff @(posedge clk_pix or negedge resetn) begin
    if (!resetn) begin
      vact_q       <= 1'b0;
      frame_tick_q <= 1'b0;
      fcnt_q       <= '0;
      angle_q      <= '0;
      paused_q     <= 1'b0;
      dir_q        <= 1'b0;
    end else begin
      vact_q       <= vact_d;
      frame_tick_q <= frame_tick_d;
      fcnt_q       <= fcnt_d;
      angle_q      <= angle_d;
      paused_q     <= paused_d;
      dir_q        <= dir_d;
    end
  end

  assign angle      = angle_q;
  assign frame_tick = frame_tick_q;
  assign paused     = paused_q;
  assign dir        = dir_q;

endmodule
